// File: rtl/buff_reader.sv
// buff_reader: pops a push/pop buffer by mirrored occupancy and streams the data through a 2-entry queue
module buff_reader #(
  parameter int NUMELEM = 4,
  parameter int BITDATA = 4,
  localparam int BITELEM = $clog2(NUMELEM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               buf_ready,
  input  logic               buf_push,
  output logic               buf_pop,
  input  logic [BITDATA-1:0] buf_dout,
  output logic               out_valid,
  output logic [BITDATA-1:0] out_data,
  input  logic               out_ready,
  input  logic               flush,
  output logic               flush_done,
  output logic [BITELEM:0]   occ,
  output logic               err_ovf
);
  typedef enum logic [1:0] {WAIT_RDY, RUN, FLUSH} state_t;
  state_t state, state_nx;
  logic [BITELEM:0] occ_nx;
  logic [BITDATA-1:0] q0, q1;
  logic [1:0] ocnt;
  logic hs, ovf, q_wr, flush_go;
  assign out_valid = ocnt != 2'd0;
  assign out_data = q0;
  assign hs = out_valid & out_ready;
  always_comb begin
    buf_pop = buf_ready && occ != '0 && (state == RUN ? ocnt < 2'd2 : state == FLUSH);
    ovf = buf_push && occ == (BITELEM+1)'(NUMELEM) && !buf_pop;
    occ_nx = ovf ? occ : occ + (BITELEM+1)'(buf_push) - (BITELEM+1)'(buf_pop);
    flush_done = state == FLUSH && buf_ready && occ_nx == '0;
    flush_go = state == RUN && buf_ready && flush;
    q_wr = buf_pop && state == RUN && !flush;
    state_nx = !buf_ready ? WAIT_RDY :
               state == WAIT_RDY ? RUN :
               flush_go ? FLUSH :
               flush_done ? RUN : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_RDY;
      occ <= '0;
      ocnt <= 2'd0;
      q0 <= '0;
      q1 <= '0;
      err_ovf <= 1'b0;
    end else begin
      state <= state_nx;
      occ <= occ_nx;
      err_ovf <= err_ovf | ovf;
      ocnt <= flush_go ? 2'd0 : ocnt + 2'(q_wr) - 2'(hs);
      if (hs) q0 <= q1;
      // a write lands in the slot that is the head after this cycle's removal
      if (q_wr && ocnt == 2'(hs)) q0 <= buf_dout;
      else if (q_wr) q1 <= buf_dout;
    end
  end
endmodule

// File: tb/tb_buff_reader.sv
// tb_buff_reader: randomized scoreboard bench; the bench itself plays the attached buffer
module tb_buff_reader;
  localparam int N = 4, W = 4;
  logic clk = 0, rst = 1, buf_ready = 0, buf_push = 0, out_ready = 0, flush = 0;
  logic [W-1:0] buf_dout = '0, push_data = '0;
  logic buf_pop, out_valid, flush_done, err_ovf;
  logic [W-1:0] out_data;
  logic [$clog2(N):0] occ;
  logic [W-1:0] bq[$], eq[$];
  int mst = 0;
  bit merr = 0;
  int checks = 0, errors = 0;

  buff_reader #(.NUMELEM(N), .BITDATA(W)) dut (
    .clk(clk), .rst(rst), .buf_ready(buf_ready), .buf_push(buf_push), .buf_pop(buf_pop),
    .buf_dout(buf_dout), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .flush(flush), .flush_done(flush_done), .occ(occ), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: mst 0=wait 1=run 2=flush; bq = buffer contents, eq = output queue contents
  always @(negedge clk) begin
    int sz;
    bit ep, efd, hs;
    logic [W-1:0] v;
    sz = bq.size();
    ep = buf_ready && sz != 0 && (mst == 1 ? eq.size() < 2 : mst == 2);
    efd = mst == 2 && buf_ready && (sz + int'(buf_push) - int'(ep)) == 0;
    hs = eq.size() != 0 && out_ready;
    chk("occ", occ, sz);
    chk("err_ovf", err_ovf, merr);
    chk("out_valid", out_valid, eq.size() != 0);
    chk("buf_pop", buf_pop, ep);
    chk("flush_done", flush_done, efd);
    if (hs) chk("out_data", out_data, eq.pop_front());
    if (rst) begin
      bq.delete();
      eq.delete();
      mst = 0;
      merr = 0;
    end else begin
      buf_dout = sz != 0 ? bq[0] : '0;
      if (ep) begin
        v = bq.pop_front();
        if (mst == 1 && !flush) eq.push_back(v);
      end
      if (buf_push) begin
        if (sz == N && !ep) merr = 1;
        else bq.push_back(push_data);
      end
      if (mst == 1 && buf_ready && flush) eq.delete();
      mst = !buf_ready ? 0 : mst == 0 ? 1 : (mst == 1 && flush) ? 2 : efd ? 1 : mst;
    end
  end

  task automatic cyc(input bit p, input int d, input bit r, input bit ordy, input bit f, input bit rs);
    buf_push = p;
    push_data = W'(d);
    buf_ready = r;
    out_ready = ordy;
    flush = f;
    rst = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d0[3] = '{3, 5, 9};
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("rst_out_data", out_data, 0);
    cyc(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, d0[i], 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 0, 0);
    for (int i = 1; i <= 4; i++) cyc(1, i, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0);
    chk("held_occ", occ, 2);
    chk("held_data", out_data, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 10 + i, 1, 0, 0, 0);
    cyc(1, 7, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("ovf_sticky", err_ovf, 1);
    chk("ovf_occ", occ, N);
    cyc(0, 0, 1, 0, 1, 0);
    chk("flush_valid", out_valid, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0, 0);
    chk("flush_occ", occ, 0);
    for (int i = 0; i < 4; i++) cyc(1, 2 + i, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(i % 2, 8 + i, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1 + i, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 1);
    chk("rst_occ", occ, 0);
    chk("rst_err", err_ovf, 0);
    chk("rst_valid", out_valid, 0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(1, 0), int'($urandom_range(15, 0)), $urandom_range(9, 0) != 0,
          $urandom_range(2, 0) != 0, $urandom_range(39, 0) == 0, $urandom_range(499, 0) == 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 1, 0, 0);
    chk("drain_out", eq.size(), 0);
    chk("drain_buf", bq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
